// File: rtl/gen_pkg.sv
// Shared constants and helpers for the gen_* delay/synchroniser blocks.
package gen_pkg;

    localparam int   GEN_SYNC_DP_MAX  = 16;
    localparam logic GEN_SYNC_RST_BIT = 1'b0;

    function automatic int clog2_f(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/gen_sync_stage.sv
// gen_sync_stage: one {valid, data} pipeline register with async reset,
// synchronous flush and advance enable.
module gen_sync_stage #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [DW:0] i_d,
    output logic [DW:0] o_q
);

    logic [DW:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {1'b0, RST_VAL};
        end else if (i_flush) begin
            r_q <= {1'b0, RST_VAL};
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/gen_sync_pipe.sv
// gen_sync_pipe: DP-stage delay/synchroniser with valid tracking, stall, flush,
// occupancy count and edge pulses. Define GEN_SYNC_PIPE_FILTER_EN for the glitch filter stage.
module gen_sync_pipe
    import gen_pkg::*;
#(
    parameter int            DP      = 2,
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = {DW{GEN_SYNC_RST_BIT}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [DW-1:0]              din,
    input  logic                       din_vld,
    output logic [DW-1:0]              dout,
    output logic                       dout_vld,
    output logic [DW-1:0]              rise,
    output logic [DW-1:0]              fall,
    output logic [clog2_f(DP+1)-1:0]   occ
);

    localparam int OW = clog2_f(DP + 1);

    logic [DW:0]   w_d [DP];
    logic [DW:0]   w_q [DP];
    logic [DP-1:0] w_vld;
    logic [DW-1:0] w_ref;
    logic [DW-1:0] w_ref_nxt;
    logic          w_in_vld;
    logic [DW-1:0] w_rise_nxt;
    logic [DW-1:0] w_fall_nxt;
    logic [DW-1:0] r_rise;
    logic [DW-1:0] r_fall;
    logic [OW-1:0] r_occ;

    if (DP < 1 || DP > GEN_SYNC_DP_MAX) begin : g_bad_dp
        $error("gen_sync_pipe: DP=%0d outside 1..%0d", DP, GEN_SYNC_DP_MAX);
    end

    for (genvar k = 0; k < DP; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_d[k] = {din_vld, din};
        end else begin : g_body
            assign w_d[k] = w_q[k-1];
        end

        gen_sync_stage #(
            .DW      (DW),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (en),
            .i_flush (flush),
            .i_d     (w_d[k]),
            .o_q     (w_q[k])
        );

        assign w_vld[k] = w_q[k][DW];
    end

    // NOTE: defaults come first so no path through this block can infer a latch.
    always_comb begin
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        if (w_in_vld) begin
            w_rise_nxt = w_ref_nxt & ~w_ref;
            w_fall_nxt = ~w_ref_nxt & w_ref;
        end
    end

    // Pulses are only produced on an advance, so a stall clears them after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else if (flush || !en) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (en) begin
            if (din_vld && !w_vld[DP-1]) begin
                r_occ <= r_occ + OW'(1);
            end else if (!din_vld && w_vld[DP-1]) begin
                r_occ <= r_occ - OW'(1);
            end
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;

`ifdef GEN_SYNC_PIPE_FILTER_EN
    localparam int PRV = (DP >= 2) ? DP - 2 : 0;

    logic [DW-1:0] r_flt;
    logic          r_flt_vld;
    logic [OW-1:0] r_occ_out;
    logic [DW-1:0] w_flt_nxt;

    if (DP < 2) begin : g_bad_flt
        $error("gen_sync_pipe: filter build needs DP >= 2, got %0d", DP);
    end

    // The filter only accepts a value once the last two stages agree on it.
    assign w_flt_nxt = (w_q[DP-1][DW-1:0] == w_q[PRV][DW-1:0]) ? w_q[DP-1][DW-1:0] : r_flt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flt     <= RST_VAL;
            r_flt_vld <= 1'b0;
            r_occ_out <= '0;
        end else if (flush) begin
            r_flt     <= RST_VAL;
            r_flt_vld <= 1'b0;
            r_occ_out <= '0;
        end else if (en) begin
            r_flt     <= w_flt_nxt;
            r_flt_vld <= w_vld[DP-1];
            r_occ_out <= r_occ;
        end
    end

    assign w_ref     = r_flt;
    assign w_ref_nxt = w_flt_nxt;
    assign w_in_vld  = w_vld[DP-1];
    assign dout      = r_flt;
    assign dout_vld  = r_flt_vld;
    assign occ       = r_occ_out;
`else
    assign w_ref     = w_q[DP-1][DW-1:0];
    assign w_ref_nxt = w_d[DP-1][DW-1:0];
    assign w_in_vld  = w_d[DP-1][DW];
    assign dout      = w_ref;
    assign dout_vld  = w_vld[DP-1];
    assign occ       = r_occ;
`endif

endmodule

// File: tb/tb_gen_sync_pipe.sv
// Directed bench for gen_sync_pipe: DP=1..4 instances share one stimulus stream,
// each scenario checks the instance it targets.
module tb_gen_sync_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] din;
    logic       din_vld;

    int checks;
    int errors;

`ifndef GEN_SYNC_PIPE_FILTER_EN
    logic [7:0] dout1, rise1, fall1;
    logic       vld1;
    logic [0:0] occ1;
`endif
    logic [7:0] dout2, rise2, fall2;
    logic       vld2;
    logic [1:0] occ2;
    logic [7:0] dout3, rise3, fall3;
    logic       vld3;
    logic [1:0] occ3;
    logic [7:0] dout4, rise4, fall4;
    logic       vld4;
    logic [2:0] occ4;

`ifndef GEN_SYNC_PIPE_FILTER_EN
    gen_sync_pipe #(.DP(1), .DW(8)) u_dp1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .dout(dout1), .dout_vld(vld1), .rise(rise1), .fall(fall1), .occ(occ1)
    );
`endif
    gen_sync_pipe #(.DP(2), .DW(8)) u_dp2 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .dout(dout2), .dout_vld(vld2), .rise(rise2), .fall(fall2), .occ(occ2)
    );
    gen_sync_pipe #(.DP(3), .DW(8)) u_dp3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .dout(dout3), .dout_vld(vld3), .rise(rise3), .fall(fall3), .occ(occ3)
    );
    gen_sync_pipe #(.DP(4), .DW(8)) u_dp4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .dout(dout4), .dout_vld(vld4), .rise(rise4), .fall(fall4), .occ(occ4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Internal occupancy must always equal the number of valid stages.
    always @(negedge clk) begin
        assert (int'(u_dp2.r_occ) == $countones(u_dp2.w_vld))
            else $error("FAIL occ_invariant dp2 occ=%0d vld=%b", u_dp2.r_occ, u_dp2.w_vld);
        assert (int'(u_dp3.r_occ) == $countones(u_dp3.w_vld))
            else $error("FAIL occ_invariant dp3 occ=%0d vld=%b", u_dp3.r_occ, u_dp3.w_vld);
        assert (int'(u_dp4.r_occ) == $countones(u_dp4.w_vld))
            else $error("FAIL occ_invariant dp4 occ=%0d vld=%b", u_dp4.r_occ, u_dp4.w_vld);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        flush = 1'b1; en = 1'b1; din_vld = 1'b0; din = 8'h00;
        tick();
        flush = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (dout2 !== 8'h00) begin errors++; $display("FAIL reset_dout2 got=%h exp=00", dout2); end
        checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL reset_vld2 got=%b exp=0", vld2); end
        checks++; if (occ2 !== 2'd0) begin errors++; $display("FAIL reset_occ2 got=%0d exp=0", occ2); end
        checks++; if (rise2 !== 8'h00 || fall2 !== 8'h00) begin errors++; $display("FAIL reset_pulses2 got=%h/%h exp=00/00", rise2, fall2); end
        checks++; if (dout4 !== 8'h00 || vld4 !== 1'b0) begin errors++; $display("FAIL reset_dp4 got=%h/%b exp=00/0", dout4, vld4); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        flush_all();
        en = 1'b1; din_vld = 1'b1; din = 8'hA5;
        tick();
        checks++; if (dout2 !== 8'h00) begin errors++; $display("FAIL basic_dout_e1 got=%h exp=00", dout2); end
        checks++; if (occ2 !== 2'd1) begin errors++; $display("FAIL basic_occ_e1 got=%0d exp=1", occ2); end
        checks++; if (rise2 !== 8'h00) begin errors++; $display("FAIL basic_rise_e1 got=%h exp=00", rise2); end
        tick();
        checks++; if (dout2 !== 8'hA5) begin errors++; $display("FAIL basic_dout_e2 got=%h exp=a5", dout2); end
        checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL basic_vld_e2 got=%b exp=1", vld2); end
        checks++; if (occ2 !== 2'd2) begin errors++; $display("FAIL basic_occ_e2 got=%0d exp=2", occ2); end
        checks++; if (rise2 !== 8'hA5 || fall2 !== 8'h00) begin errors++; $display("FAIL basic_pulse_e2 got=%h/%h exp=a5/00", rise2, fall2); end
        tick();
        checks++; if (rise2 !== 8'h00) begin errors++; $display("FAIL basic_rise_e3 got=%h exp=00", rise2); end
        checks++; if (occ2 !== 2'd2 || dout2 !== 8'hA5) begin errors++; $display("FAIL basic_hold_e3 got=%0d/%h exp=2/a5", occ2, dout2); end
    endtask

    task automatic test_stall();
        flush_all();
        en = 1'b1; din_vld = 1'b1;
        din = 8'h11; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        checks++; if (dout3 !== 8'h11 || occ3 !== 2'd3) begin errors++; $display("FAIL stall_fill got=%h/%0d exp=11/3", dout3, occ3); end
        checks++; if (rise3 !== 8'h11) begin errors++; $display("FAIL stall_fill_rise got=%h exp=11", rise3); end
        en = 1'b0; din = 8'h44;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (dout3 !== 8'h11 || vld3 !== 1'b1 || occ3 !== 2'd3) begin
                errors++; $display("FAIL stall_frozen[%0d] got=%h/%b/%0d exp=11/1/3", i, dout3, vld3, occ3);
            end
            checks++; if (rise3 !== 8'h00 || fall3 !== 8'h00) begin
                errors++; $display("FAIL stall_pulses[%0d] got=%h/%h exp=00/00", i, rise3, fall3);
            end
        end
        en = 1'b1;
        tick();
        checks++; if (dout3 !== 8'h22 || occ3 !== 2'd3) begin errors++; $display("FAIL stall_resume got=%h/%0d exp=22/3", dout3, occ3); end
        checks++; if (rise3 !== 8'h22 || fall3 !== 8'h11) begin errors++; $display("FAIL stall_resume_pulse got=%h/%h exp=22/11", rise3, fall3); end
    endtask

    task automatic test_flush();
        flush = 1'b1; en = 1'b1; din_vld = 1'b1; din = 8'h5A;
        tick();
        checks++; if (dout3 !== 8'h00 || vld3 !== 1'b0 || occ3 !== 2'd0) begin
            errors++; $display("FAIL flush_clear got=%h/%b/%0d exp=00/0/0", dout3, vld3, occ3);
        end
        checks++; if (rise3 !== 8'h00 || fall3 !== 8'h00) begin errors++; $display("FAIL flush_pulses got=%h/%h exp=00/00", rise3, fall3); end
        flush = 1'b0; din_vld = 1'b0; din = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dout3 !== 8'h00 || vld3 !== 1'b0 || occ3 !== 2'd0) begin
                errors++; $display("FAIL flush_drain[%0d] got=%h/%b/%0d exp=00/0/0", i, dout3, vld3, occ3);
            end
        end
    endtask

`ifndef GEN_SYNC_PIPE_FILTER_EN
    task automatic test_dp1();
        flush_all();
        en = 1'b1;
        din = 8'h0F; din_vld = 1'b1; tick();
        checks++; if (dout1 !== 8'h0F || occ1 !== 1'b1 || rise1 !== 8'h0F) begin
            errors++; $display("FAIL dp1_a got=%h/%0d/%h exp=0f/1/0f", dout1, occ1, rise1);
        end
        din = 8'h0F; din_vld = 1'b0; tick();
        checks++; if (occ1 !== 1'b0 || vld1 !== 1'b0 || rise1 !== 8'h00) begin
            errors++; $display("FAIL dp1_b got=%0d/%b/%h exp=0/0/00", occ1, vld1, rise1);
        end
        din = 8'hF0; din_vld = 1'b1; tick();
        checks++; if (occ1 !== 1'b1 || dout1 !== 8'hF0) begin errors++; $display("FAIL dp1_c got=%0d/%h exp=1/f0", occ1, dout1); end
        checks++; if (rise1 !== 8'hF0 || fall1 !== 8'h0F) begin errors++; $display("FAIL dp1_c_pulse got=%h/%h exp=f0/0f", rise1, fall1); end
        din = 8'h00; din_vld = 1'b0; tick();
        checks++; if (occ1 !== 1'b0 || dout1 !== 8'h00 || rise1 !== 8'h00 || fall1 !== 8'h00) begin
            errors++; $display("FAIL dp1_d got=%0d/%h/%h/%h exp=0/00/00/00", occ1, dout1, rise1, fall1);
        end
    endtask

    task automatic test_reset_mid();
        flush_all();
        en = 1'b1; din_vld = 1'b1; din = 8'h3C;
        tick();
        tick();
        checks++; if (occ4 !== 3'd2 || dout2 !== 8'h3C) begin errors++; $display("FAIL rstmid_pre got=%0d/%h exp=2/3c", occ4, dout2); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (occ4 !== 3'd0 || vld4 !== 1'b0 || dout4 !== 8'h00) begin
            errors++; $display("FAIL rstmid_dp4 got=%0d/%b/%h exp=0/0/00", occ4, vld4, dout4);
        end
        checks++; if (dout2 !== 8'h00 || rise2 !== 8'h00 || occ2 !== 2'd0) begin
            errors++; $display("FAIL rstmid_dp2 got=%h/%h/%0d exp=00/00/0", dout2, rise2, occ2);
        end
        tick();
        rst = 1'b0; en = 1'b1; din_vld = 1'b1; din = 8'hFF;
        tick(); tick(); tick();
        checks++; if (dout4 !== 8'h00 || vld4 !== 1'b0) begin errors++; $display("FAIL rstmid_e3 got=%h/%b exp=00/0", dout4, vld4); end
        tick();
        checks++; if (dout4 !== 8'hFF || vld4 !== 1'b1 || occ4 !== 3'd4) begin
            errors++; $display("FAIL rstmid_e4 got=%h/%b/%0d exp=ff/1/4", dout4, vld4, occ4);
        end
        checks++; if (rise4 !== 8'hFF) begin errors++; $display("FAIL rstmid_rise got=%h exp=ff", rise4); end
    endtask
`else
    task automatic test_filter();
        flush_all();
        en = 1'b1; din_vld = 1'b1;
        din = 8'h00; tick();
        din = 8'h01; tick();
        din = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (dout2 !== 8'h00 || rise2 !== 8'h00 || fall2 !== 8'h00) begin
                errors++; $display("FAIL filter_glitch[%0d] got=%h/%h/%h exp=00/00/00", i, dout2, rise2, fall2);
            end
        end
        din = 8'h01;
        tick(); tick();
        checks++; if (dout2 !== 8'h00) begin errors++; $display("FAIL filter_e2 got=%h exp=00", dout2); end
        tick();
        checks++; if (dout2 !== 8'h01 || vld2 !== 1'b1) begin errors++; $display("FAIL filter_e3 got=%h/%b exp=01/1", dout2, vld2); end
        checks++; if (rise2 !== 8'h01 || fall2 !== 8'h00) begin errors++; $display("FAIL filter_pulse got=%h/%h exp=01/00", rise2, fall2); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; din = 8'h00; din_vld = 1'b0;
        test_reset();
`ifndef GEN_SYNC_PIPE_FILTER_EN
        test_basic();
        test_stall();
        test_flush();
        test_dp1();
        test_reset_mid();
`else
        test_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_sync_pipe.md
Name: gen_sync_pipe

Overview:
Parametrised multi-bit delay/synchroniser pipeline of DP register stages. Adds per-stage valid tracking, an advance enable (stall), a synchronous flush, an occupancy counter and registered per-bit rise/fall pulses. Used for tick/strobe alignment and level synchronisation between core, peripheral and debug logic. Intended to supersede plain fixed-depth reset-to-zero delay chains.

Parameters:
DP, 2, number of pipeline stages; legal range 1..16.
DW, 32, data width in bits.
RST_VAL, {DW{1'b0}}, reset and flush value of every data stage.

Ports:
clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
en  input  1  advance; pipeline shifts only when 1.
flush  input  1  synchronous clear of the pipeline contents.
din  input  DW  data into stage 0.
din_vld  input  1  valid tag for din.
dout  output  DW  data out of the last stage.
dout_vld  output  1  valid tag of the last stage.
rise  output  DW  one-cycle pulse per bit on a 0->1 change of dout.
fall  output  DW  one-cycle pulse per bit on a 1->0 change of dout.
occ  output  $clog2(DP+1)  number of stages holding valid data.

Behaviour:
- Only one clock is used. Reset is asynchronous and active-high.
- State: data_q[0..DP-1], vld_q[0..DP-1], rise_q, fall_q, occ_q.
- Reset assertion clears all state immediately, mid-operation included:
  - data_q = RST_VAL, vld_q = 0, rise = fall = 0, occ = 0.
  - Hence dout = RST_VAL and dout_vld = 0 during reset.
- Priority per edge: flush > en > hold.
- flush=1:
  - All data_q become RST_VAL; vld_q, rise_q, fall_q and occ_q become 0.
  - din is discarded, whatever the value of en.
- en=1, flush=0:
  - data_q[0] <= din and vld_q[0] <= din_vld.
  - For k>0, data_q[k] <= data_q[k-1] and vld_q[k] <= vld_q[k-1].
- en=0, flush=0: every stage holds. rise_q and fall_q drive 0.
- Latency: DP edges from din to dout with en held high. A DP=1 build gives a single register.
- Outputs: dout = data_q[DP-1]; dout_vld = vld_q[DP-1].
- Edge pulses are registered and coincide with the cycle in which dout takes its new value:
  - On an advance: rise_q <= nxt & ~dout and fall_q <= ~nxt & dout.
  - nxt = data_q[DP-2], or din when DP=1.
  - Pulses are gated by the incoming valid (vld_q[DP-2], or din_vld when DP=1); an invalid entry produces 0.
  - Pulses last exactly one cycle, even if en stays 0 afterwards.
- occ counter, updated on an advance: occ_q <= occ_q + in - out.
  - in = din_vld; out = vld_q[DP-1].
  - occ never exceeds DP and never wraps; a simultaneous enter and leave leaves occ unchanged.
- Invariant: occ equals popcount(vld_q) at all times; the bench asserts this.

Optional Feature:
GEN_SYNC_PIPE_FILTER_EN
- Defined:
  - Adds one filter register flt_q (reset and flush value RST_VAL).
  - On an advance, flt_q <= data_q[DP-1] only when data_q[DP-1] == data_q[DP-2]; otherwise it holds.
  - dout = flt_q and latency becomes DP+1. Edge pulses are computed against flt_q.
  - dout_vld and occ are delayed one additional stage to match.
  - DP >= 2 is required; an elaboration-time check fails otherwise.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Shared package gen_pkg holds:
  - the function clog2_f, used for the occ width;
  - the constant GEN_SYNC_DP_MAX = 16 used by the range check;
  - the default RST_VAL constant.
- One natural sub-module, gen_sync_stage: a single DW+1-bit register with async active-high reset, en, flush and a reset value parameter. The top generates DP instances of it plus the edge, occ and filter logic.

Test Plan:
- DP=2, DW=8: en=1, din_vld=1, din 0x00 -> 0xA5 at cycle 0 -> dout=0xA5 at edge 2; rise=0xA5 for exactly one cycle; occ goes 1 then 2.
- DP=3: stream of 3 valid words, then en=0 for 5 cycles -> dout, occ=3 and dout_vld all frozen; rise and fall are 0 throughout the stall.
- DP=3, pipe full: flush together with en=1 and din_vld=1 -> next cycle dout=RST_VAL, dout_vld=0, occ=0; the din of that cycle never appears.
- DP=4: rst asserted mid-stream between edges -> outputs return to reset values before the next clock edge. Reset released, then din=0xFF -> dout=0xFF after 4 edges.
- DP=1, alternating din_vld 1/0 with en=1 -> occ toggles 1/0; a 0x0F -> 0xF0 transition gives rise=0xF0 and fall=0x0F in the same cycle.
- With GEN_SYNC_PIPE_FILTER_EN, DP=2: a single-cycle glitch 0x00 -> 0x01 -> 0x00 -> dout stays 0x00 and no pulse is produced. A stable 0x01 appears at dout after 3 edges.
